// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus an MMIO page (TXDATA/STATUS/CYCLE); CYCLE counter built only with DMEM_CYCLE_COUNTER_EN.
// Latency: loads are combinational from aluout; stores, FIFO pushes and register writes land at the next clk edge.
// Backpressure: tx_ready low holds tx_data; a TXDATA push into a full FIFO with no same-edge pop is dropped and sets overflow.

// Transmit byte FIFO: circular buffer with count; a push while full is taken only if a pop shares the edge.
// Latency: a pushed entry appears at out_dat one edge after the push (no bypass).
// Backpressure: out_rdy low holds out_dat stable; in_rdy low means a push would be refused.
module mips_dmem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push;
    logic             pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign out_vld = !empty;
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld & out_rdy;
    assign in_rdy  = !full | pop;
    assign push    = in_vld & in_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_dat;
    end
endmodule

module mips_dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_FFF0;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FFF4;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_FFF8;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic          is_ram;
    logic          is_txdata;
    logic          is_status;
    logic          is_cycle;
    logic          tx_push;
    logic          tx_accept;
    logic          tx_full;
    logic          tx_empty;
    logic          overflow;
    logic [31:0]   cycle_val;

    // RAM ignores upper address bits, so it aliases across the low half of the space.
    assign widx      = aluout[AW+1:2];
    assign is_ram    = !aluout[31];
    assign is_txdata = (aluout == ADDR_TXDATA);
    assign is_status = (aluout == ADDR_STATUS);
    assign is_cycle  = (aluout == ADDR_CYCLE);
    assign tx_push   = memwrite & is_txdata;

    always_ff @(posedge clk) begin
        if (memwrite && is_ram)
            ram[widx] <= writedata;
    end

    mips_dmem_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (tx_push),
        .in_rdy  (tx_accept),
        .in_dat  (writedata[7:0]),
        .out_vld (tx_valid),
        .out_rdy (tx_ready),
        .out_dat (tx_data),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    // A dropped push takes priority over a same-edge clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (tx_push && !tx_accept)
            overflow <= 1'b1;
        else if (memwrite && is_status && writedata[2])
            overflow <= 1'b0;
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cycle <= '0;
        else if (memwrite && is_cycle)
            cycle <= writedata;
        else
            cycle <= cycle + 32'd1;
    end

    assign cycle_val = cycle;
`else
    assign cycle_val = '0;
`endif

    always_comb begin
        readdata = '0;
        if (is_ram)
            readdata = ram[widx];
        else if (is_status)
            readdata = {29'b0, overflow, tx_full, tx_empty};
        else if (is_cycle)
            readdata = cycle_val;
    end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: queue/array reference model checked every cycle, plus directed literal checks.
module tb_mips_dmem_responder;
    localparam int DEPTH = 64;
    localparam int FDEPTH = 4;
    localparam logic [31:0] TX  = 32'hFFFF_FFF0;
    localparam logic [31:0] ST  = 32'hFFFF_FFF4;
    localparam logic [31:0] CYC = 32'hFFFF_FFF8;
`ifdef DMEM_CYCLE_COUNTER_EN
    localparam bit CYC_ON = 1'b1;
`else
    localparam bit CYC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int passes = 0;

    mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FDEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  m_q [$];
    bit          m_ovf = 1'b0;
    logic [31:0] m_cyc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[30:2]) % DEPTH;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (!a[31]) begin
            if (m_ram.exists(widx(a)))
                return m_ram[widx(a)];
            known = 1'b0;
            return '0;
        end
        if (a == ST)
            return {29'b0, m_ovf, m_q.size() == FDEPTH, m_q.size() == 0};
        if (a == CYC)
            return CYC_ON ? m_cyc : 32'h0;
        return '0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit popped;
        if (!reset_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cyc = '0;
        end else begin
            popped = (m_q.size() > 0) && tx_ready;
            if (memwrite && !aluout[31])
                m_ram[widx(aluout)] = writedata;
            m_cyc = (memwrite && aluout == CYC) ? writedata : m_cyc + 32'd1;
            if (popped)
                void'(m_q.pop_front());
            if (memwrite && aluout == TX) begin
                if (m_q.size() < FDEPTH)
                    m_q.push_back(writedata[7:0]);
                else
                    m_ovf = 1'b1;
            end else if (memwrite && aluout == ST && writedata[2]) begin
                m_ovf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        bit          known;
        logic [31:0] e;
        e = exp_read(aluout, known);
        if (known)
            chk("model_readdata", readdata, e);
        chk("model_tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() > 0});
        if (m_q.size() > 0)
            chk("model_tx_data", {24'b0, tx_data}, {24'b0, m_q[0]});
    end

    task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        @(posedge clk);
        #1;
        memwrite  = mw;
        aluout    = a;
        writedata = wd;
        tx_ready  = rdy;
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        memwrite  = 1'b0;
        aluout    = CYC;
        writedata = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("cycle_after_release", readdata, 32'h0);
        drive(0, CYC, 0, 0);
        chk("cycle_plus_one", readdata, CYC_ON ? 32'h1 : 32'h0);
        drive(0, ST, 0, 0);
        chk("reset_status", readdata, 32'h1);

        // RAM store/load and aliasing
        drive(1, 32'h10, 32'hDEAD_BEEF, 0);
        drive(0, 32'h10, 0, 0);
        chk("ram_load", readdata, 32'hDEAD_BEEF);
        aluout = 32'h13;
        #1;
        chk("ram_load_unaligned", readdata, 32'hDEAD_BEEF);
        aluout = 32'h110;
        #1;
        chk("ram_alias", readdata, 32'hDEAD_BEEF);
        drive(1, 32'h10, 32'h1234_5678, 0);
        chk("ram_old_before_edge", readdata, 32'hDEAD_BEEF);
        drive(0, 32'h10, 0, 0);
        chk("ram_new_after_edge", readdata, 32'h1234_5678);

        // FIFO ordering
        drive(1, TX, 32'h41, 0);
        drive(1, TX, 32'h42, 0);
        drive(0, ST, 0, 1);
        chk("fifo_status_two", readdata, 32'h0);
        chk("fifo_first", {24'b0, tx_data}, 32'h41);
        drive(0, ST, 0, 1);
        chk("fifo_second", {24'b0, tx_data}, 32'h42);
        drive(0, ST, 0, 0);
        chk("fifo_drained_valid", {31'b0, tx_valid}, 32'h0);
        chk("fifo_drained_status", readdata, 32'h1);

        // Overflow: fifth byte dropped
        for (int i = 0; i < 5; i++)
            drive(1, TX, 32'h61 + i, 0);
        drive(0, ST, 0, 0);
        chk("ovf_status", readdata, 32'h6);
        for (int i = 0; i < 4; i++) begin
            drive(0, ST, 0, 1);
            chk("ovf_drain", {24'b0, tx_data}, 32'h61 + i);
        end
        drive(0, ST, 0, 0);
        chk("ovf_after_drain", readdata, 32'h5);
        drive(1, ST, 32'h4, 0);
        drive(0, ST, 0, 0);
        chk("ovf_cleared", readdata, 32'h1);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++)
            drive(1, TX, 32'h51 + i, 0);
        drive(1, TX, 32'h55, 1);
        chk("full_head", {24'b0, tx_data}, 32'h51);
        drive(0, ST, 0, 0);
        chk("full_pushpop_status", readdata, 32'h2);
        for (int i = 0; i < 4; i++) begin
            drive(0, ST, 0, 1);
            chk("full_drain", {24'b0, tx_data}, 32'h52 + i);
        end
        drive(0, ST, 0, 0);
        chk("full_empty_after", {31'b0, tx_valid}, 32'h0);

        // Counter load and wrap
        drive(1, CYC, 32'hFFFF_FFFE, 0);
        drive(0, CYC, 0, 0);
        chk("cycle_loaded", readdata, CYC_ON ? 32'hFFFF_FFFE : 32'h0);
        drive(0, CYC, 0, 0);
        chk("cycle_max", readdata, CYC_ON ? 32'hFFFF_FFFF : 32'h0);
        drive(0, CYC, 0, 0);
        chk("cycle_wrap", readdata, 32'h0);

        // Unmapped MMIO reads zero
        drive(1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0);
        chk("unmapped_read", readdata, 32'h0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++)
            drive(1, TX, 32'h71 + i, 0);
        drive(0, ST, 0, 0);
        chk("pre_reset_valid", {31'b0, tx_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midreset_valid", {31'b0, tx_valid}, 32'h0);
        chk("midreset_status", readdata, 32'h1);
        reset_n = 1'b1;
        aluout = 32'h10;
        #1;
        chk("ram_retained", readdata, 32'h1234_5678);
        drive(0, 32'h10, 0, 0);
        drive(0, 32'h10, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
